// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: carries decoded ID fields into EX and detects load-use hazards.
// It inserts bubbles on a hazard or a flush, freezes on EX hold, and counts inserted bubbles.
module id_ex_stage_reg #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [XLEN-1:0]  id_pc,
    input  logic [XLEN-1:0]  id_rs1_data,
    input  logic [XLEN-1:0]  id_rs2_data,
    input  logic [XLEN-1:0]  id_imm,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [4:0]       id_rd,
    input  logic [1:0]       id_ALUop,
    input  logic             id_funct7,
    input  logic [2:0]       id_funct3,
    input  logic             id_ALUsrc,
    input  logic             id_MemRead,
    input  logic             id_MemWrite,
    input  logic             id_RegWrite,
    input  logic             id_MemtoReg,
    input  logic             id_Branch,
    input  logic             flush,
    input  logic             ex_hold,
    output logic             ex_valid,
    output logic [XLEN-1:0]  ex_pc,
    output logic [XLEN-1:0]  ex_rs1_data,
    output logic [XLEN-1:0]  ex_rs2_data,
    output logic [XLEN-1:0]  ex_imm,
    output logic [4:0]       ex_rs1,
    output logic [4:0]       ex_rs2,
    output logic [4:0]       ex_rd,
    output logic [1:0]       ex_ALUop,
    output logic             ex_funct7,
    output logic [2:0]       ex_funct3,
    output logic             ex_ALUsrc,
    output logic             ex_MemRead,
    output logic             ex_MemWrite,
    output logic             ex_RegWrite,
    output logic             ex_MemtoReg,
    output logic             ex_Branch,
    output logic             stall_id,
    output logic [CNT_W-1:0] bubble_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic haz;
    logic load_bubble;
    logic load_id;

    // rs2 is compared even for I-type: a spurious stall costs one cycle, a missed one is wrong.
    always_comb begin
        haz = ex_valid & ex_MemRead & id_valid & (ex_rd != 5'd0) &
              ((ex_rd == id_rs1) | (ex_rd == id_rs2));
        stall_id    = (haz | ex_hold) & ~flush;
        load_bubble = rst | flush | (~ex_hold & haz);
        load_id     = ~rst & ~flush & ~ex_hold & ~haz;
    end

    always_ff @(posedge clk) begin
        if (load_bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ALUop    <= '0;
            ex_funct7   <= 1'b0;
            ex_funct3   <= '0;
            ex_ALUsrc   <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemtoReg <= 1'b0;
            ex_Branch   <= 1'b0;
        end else if (load_id) begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_ALUop    <= id_ALUop;
            ex_funct7   <= id_funct7;
            ex_funct3   <= id_funct3;
            ex_ALUsrc   <= id_ALUsrc;
            ex_MemRead  <= id_MemRead;
            ex_MemWrite <= id_MemWrite;
            ex_RegWrite <= id_RegWrite;
            ex_MemtoReg <= id_MemtoReg;
            ex_Branch   <= id_Branch;
        end
    end

    // Flush outranks hold and hazard, so at most one counter moves per edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (flush) begin
            if (flush_cnt != CNT_MAX)
                flush_cnt <= flush_cnt + CNT_ONE;
        end else if (!ex_hold && haz) begin
            if (bubble_cnt != CNT_MAX)
                bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg covering reset, pass-through, load-use, flush, hold and
// counter saturation; a 2-bit counter width makes saturation reachable in a few bubbles.
module tb_id_ex_stage_reg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 2;

    // {ALUsrc, MemRead, MemWrite, RegWrite, MemtoReg, Branch}
    localparam logic [5:0] CTL_LW = 6'b110110;
    localparam logic [5:0] CTL_R  = 6'b000100;
    localparam logic [5:0] CTL_I  = 6'b100100;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [XLEN-1:0]  id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic [1:0]       id_ALUop;
    logic             id_funct7;
    logic [2:0]       id_funct3;
    logic             id_ALUsrc, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg, id_Branch;
    logic             flush, ex_hold;
    logic             ex_valid;
    logic [XLEN-1:0]  ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]       ex_rs1, ex_rs2, ex_rd;
    logic [1:0]       ex_ALUop;
    logic             ex_funct7;
    logic [2:0]       ex_funct3;
    logic             ex_ALUsrc, ex_MemRead, ex_MemWrite, ex_RegWrite, ex_MemtoReg, ex_Branch;
    logic             stall_id;
    logic [CNT_W-1:0] bubble_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_pc(id_pc), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_ALUop(id_ALUop), .id_funct7(id_funct7), .id_funct3(id_funct3),
        .id_ALUsrc(id_ALUsrc), .id_MemRead(id_MemRead), .id_MemWrite(id_MemWrite),
        .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_Branch(id_Branch),
        .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_ALUop(ex_ALUop), .ex_funct7(ex_funct7), .ex_funct3(ex_funct3),
        .ex_ALUsrc(ex_ALUsrc), .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
        .stall_id(stall_id), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Data fields are derived from pc so every instruction carries distinct operands.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [1:0] op,
                         input logic f7, input logic [2:0] f3, input logic [5:0] ctl);
        id_valid    = v;
        id_pc       = pc;
        id_rs1_data = pc + 32'h0000_1000;
        id_rs2_data = pc + 32'h0000_2000;
        id_imm      = pc ^ 32'hFFFF_0000;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_ALUop    = op;
        id_funct7   = f7;
        id_funct3   = f3;
        {id_ALUsrc, id_MemRead, id_MemWrite, id_RegWrite, id_MemtoReg, id_Branch} = ctl;
    endtask

    initial begin
        // Reset with random inputs on both edges
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 2'($urandom),
                  1'($urandom), 3'($urandom), 6'($urandom));
            flush   = 1'($urandom);
            ex_hold = 1'($urandom);
            step();
        end
        rst = 1'b0; flush = 1'b0; ex_hold = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0, 3'd0, 6'd0);
        #1;
        check("rst ex_valid", ex_valid, 0);
        check("rst ex_pc", ex_pc, 0);
        check("rst ex_rs1_data", ex_rs1_data, 0);
        check("rst ex_imm", ex_imm, 0);
        check("rst ex_rd", ex_rd, 0);
        check("rst ex_ALUop", ex_ALUop, 0);
        check("rst ex_RegWrite", ex_RegWrite, 0);
        check("rst bubble_cnt", bubble_cnt, 0);
        check("rst flush_cnt", flush_cnt, 0);
        check("rst stall_id", stall_id, 0);

        // Pass-through: add x3,x1,x2
        drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 2'b10, 1'b0, 3'b000, CTL_R);
        step();
        check("pass ex_valid", ex_valid, 1);
        check("pass ex_ALUop", ex_ALUop, 2);
        check("pass ex_rd", ex_rd, 3);
        check("pass ex_pc", ex_pc, 32'h100);
        check("pass ex_rs2_data", ex_rs2_data, 32'h2100);
        check("pass ex_imm", ex_imm, 32'hFFFF_0100);
        check("pass ex_RegWrite", ex_RegWrite, 1);
        check("pass stall_id", stall_id, 0);

        // Load-use on rs1: lw x5 then add x6,x5,x7
        drive(1'b1, 32'h104, 5'd1, 5'd0, 5'd5, 2'b00, 1'b0, 3'b010, CTL_LW);
        step();
        check("lw ex_MemRead", ex_MemRead, 1);
        drive(1'b1, 32'h108, 5'd5, 5'd7, 5'd6, 2'b10, 1'b0, 3'b000, CTL_R);
        #1;
        check("lu1 stall_id", stall_id, 1);
        step();
        check("lu1 bubble ex_valid", ex_valid, 0);
        check("lu1 bubble ex_RegWrite", ex_RegWrite, 0);
        check("lu1 bubble ex_pc", ex_pc, 0);
        check("lu1 bubble_cnt", bubble_cnt, 1);
        check("lu1 stall released", stall_id, 0);
        step();
        check("lu1 reload ex_valid", ex_valid, 1);
        check("lu1 reload ex_rd", ex_rd, 6);
        check("lu1 reload ex_pc", ex_pc, 32'h108);

        // Load-use on rs2: lw x9 then add x4,x1,x9
        drive(1'b1, 32'h10C, 5'd1, 5'd0, 5'd9, 2'b00, 1'b0, 3'b010, CTL_LW);
        step();
        drive(1'b1, 32'h110, 5'd1, 5'd9, 5'd4, 2'b10, 1'b0, 3'b000, CTL_R);
        #1;
        check("lu2 stall_id", stall_id, 1);
        step();
        check("lu2 bubble ex_valid", ex_valid, 0);
        check("lu2 bubble_cnt", bubble_cnt, 2);
        step();
        check("lu2 reload ex_pc", ex_pc, 32'h110);

        // lw x0 never causes a hazard
        drive(1'b1, 32'h114, 5'd1, 5'd0, 5'd0, 2'b00, 1'b0, 3'b010, CTL_LW);
        step();
        drive(1'b1, 32'h118, 5'd0, 5'd0, 5'd8, 2'b10, 1'b0, 3'b000, CTL_R);
        #1;
        check("x0 stall_id", stall_id, 0);
        step();
        check("x0 ex_valid", ex_valid, 1);
        check("x0 ex_pc", ex_pc, 32'h118);
        check("x0 bubble_cnt", bubble_cnt, 2);

        // Flush, hold and hazard in the same cycle
        drive(1'b1, 32'h120, 5'd1, 5'd0, 5'd5, 2'b00, 1'b0, 3'b010, CTL_LW);
        step();
        drive(1'b1, 32'h124, 5'd5, 5'd7, 5'd6, 2'b10, 1'b0, 3'b000, CTL_R);
        flush = 1'b1; ex_hold = 1'b1;
        #1;
        check("fl stall_id", stall_id, 0);
        step();
        flush = 1'b0; ex_hold = 1'b0;
        check("fl ex_valid", ex_valid, 0);
        check("fl ex_MemRead", ex_MemRead, 0);
        check("fl ex_rd", ex_rd, 0);
        check("fl flush_cnt", flush_cnt, 1);
        check("fl bubble_cnt", bubble_cnt, 2);

        // Hold for three cycles
        drive(1'b1, 32'h200, 5'd2, 5'd0, 5'd10, 2'b11, 1'b1, 3'b101, CTL_I);
        step();
        check("hold pre ex_funct7", ex_funct7, 1);
        check("hold pre ex_funct3", ex_funct3, 5);
        drive(1'b1, 32'h204, 5'd3, 5'd0, 5'd11, 2'b11, 1'b0, 3'b000, CTL_I);
        ex_hold = 1'b1;
        #1;
        check("hold stall_id", stall_id, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold ex_pc", ex_pc, 32'h200);
            check("hold ex_rd", ex_rd, 10);
            check("hold ex_funct7", ex_funct7, 1);
        end
        ex_hold = 1'b0;
        #1;
        check("hold release stall_id", stall_id, 0);
        step();
        check("hold release ex_pc", ex_pc, 32'h204);
        check("hold release ex_rd", ex_rd, 11);
        check("hold release ex_funct7", ex_funct7, 0);
        check("hold flush_cnt kept", flush_cnt, 1);

        // Reset while a hazard is pending
        drive(1'b1, 32'h208, 5'd1, 5'd0, 5'd5, 2'b00, 1'b0, 3'b010, CTL_LW);
        step();
        drive(1'b1, 32'h20C, 5'd5, 5'd7, 5'd6, 2'b10, 1'b0, 3'b000, CTL_R);
        #1;
        check("rsthaz stall before", stall_id, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        check("rsthaz ex_valid", ex_valid, 0);
        check("rsthaz ex_MemRead", ex_MemRead, 0);
        check("rsthaz bubble_cnt", bubble_cnt, 0);
        check("rsthaz flush_cnt", flush_cnt, 0);
        check("rsthaz stall_id", stall_id, 0);

        // Five load-use bubbles: a 2-bit counter stops at 3
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h300 + 32'(8 * i), 5'd1, 5'd0, 5'd5, 2'b00, 1'b0, 3'b010, CTL_LW);
            step();
            drive(1'b1, 32'h304 + 32'(8 * i), 5'd5, 5'd7, 5'd6, 2'b10, 1'b0, 3'b000, CTL_R);
            step();
            check("sat ex_valid", ex_valid, 0);
            check("sat bubble_cnt", bubble_cnt, (i < 3) ? i + 1 : 3);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
